// File: rtl/phy_pkg.sv
// Shared PHY definitions: control codes, frame geometry and the link state
// type, imported by both the transmit serializer and the receive deserializer.
package phy_pkg;

  localparam logic [7:0] K_COMMA    = 8'hBC;
  localparam logic [7:0] K_IDLE     = 8'h7C;
  localparam int         FRAME_BITS = 32;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } phy_state_e;

  function automatic logic [FRAME_BITS-1:0] comma_frame();
    return {4{K_COMMA}};
  endfunction

endpackage

// File: rtl/phy_tx_frame_builder.sv
// Combinational next-frame builder: four lanes packed lane0-first, with idle
// substitution for invalid lanes. Idle code is 8'h7C when PHY_TX_IDLE_7C_EN
// is defined, otherwise 8'hBC.
module phy_tx_frame_builder
  import phy_pkg::*;
(
  input  logic        i_state,
  input  logic [3:0]  i_valid,
  input  logic [7:0]  i_lane0,
  input  logic [7:0]  i_lane1,
  input  logic [7:0]  i_lane2,
  input  logic [7:0]  i_lane3,
  output logic [31:0] o_frame
);

`ifdef PHY_TX_IDLE_7C_EN
  localparam logic [7:0] IDLE_CODE = K_IDLE;
`else
  localparam logic [7:0] IDLE_CODE = K_COMMA;
`endif

  logic [7:0] w_byte0;
  logic [7:0] w_byte1;
  logic [7:0] w_byte2;
  logic [7:0] w_byte3;

  assign w_byte0 = i_valid[0] ? i_lane0 : IDLE_CODE;
  assign w_byte1 = i_valid[1] ? i_lane1 : IDLE_CODE;
  assign w_byte2 = i_valid[2] ? i_lane2 : IDLE_CODE;
  assign w_byte3 = i_valid[3] ? i_lane3 : IDLE_CODE;

  // The preamble is always pure comma, regardless of lane contents.
  always_comb begin
    o_frame = comma_frame();
    if (i_state == ACTIVE) begin
      o_frame = {w_byte0, w_byte1, w_byte2, w_byte3};
    end
  end

endmodule

// File: rtl/phy_tx_serializer.sv
// PHY transmit serializer: 4x8-bit lanes to one MSB-first serial stream,
// preceded by SYNC_FRAMES comma frames after reset. Optional PHY_TX_IDLE_7C_EN.
module phy_tx_serializer
  import phy_pkg::*;
#(
  parameter int SYNC_FRAMES = 2
)
(
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  output logic       data_out,
  output logic       load,
  output logic       active
);

  localparam logic [3:0] LAST_SYNC = 4'(SYNC_FRAMES - 1);
  localparam logic [4:0] BIT_LAST  = 5'(FRAME_BITS - 1);

  phy_state_e  r_state;
  phy_state_e  w_state_nxt;
  phy_state_e  w_build_state;
  logic [31:0] r_shreg;
  logic [31:0] w_shreg_nxt;
  logic [31:0] w_frame;
  logic [4:0]  r_bit_cnt;
  logic [3:0]  r_sync_cnt;
  logic [3:0]  w_sync_cnt_nxt;
  logic        w_boundary;
  logic        w_take_data;
  logic        w_load_nxt;

  assign w_boundary    = (r_bit_cnt == BIT_LAST);
  // Data is taken either in ACTIVE or on the boundary closing the last comma frame.
  assign w_take_data   = (r_state == ACTIVE) || (r_sync_cnt == LAST_SYNC);
  assign w_build_state = w_take_data ? ACTIVE : SYNC;
  assign w_load_nxt    = (r_bit_cnt == (BIT_LAST - 5'd1)) && w_take_data;

  phy_tx_frame_builder u_frame_builder (
    .i_state (w_build_state),
    .i_valid ({valid3, valid2, valid1, valid0}),
    .i_lane0 (data_in0),
    .i_lane1 (data_in1),
    .i_lane2 (data_in2),
    .i_lane3 (data_in3),
    .o_frame (w_frame)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_sync_cnt_nxt = r_sync_cnt;
    w_shreg_nxt    = r_shreg << 1;
    if (w_boundary) begin
      w_shreg_nxt = w_frame;
      if (r_state == SYNC) begin
        if (r_sync_cnt == LAST_SYNC) begin
          w_state_nxt = ACTIVE;
        end else begin
          w_sync_cnt_nxt = r_sync_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_state    <= SYNC;
      r_sync_cnt <= 4'd0;
      r_bit_cnt  <= 5'd0;
      r_shreg    <= comma_frame();
      data_out   <= 1'b0;
      load       <= 1'b0;
      active     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
      r_bit_cnt  <= r_bit_cnt + 5'd1;
      r_shreg    <= w_shreg_nxt;
      data_out   <= r_shreg[31];
      load       <= w_load_nxt;
      active     <= (w_state_nxt == ACTIVE);
    end
  end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Scoreboard bench for phy_tx_serializer: a stream-level model predicts every
// output cycle; a monitor compares data_out/active/load one step after each edge.
module tb_phy_tx_serializer;

  localparam int SF = 2;
  localparam int FB = 32;
`ifdef PHY_TX_IDLE_7C_EN
  localparam logic [7:0] IDLE_B = 8'h7C;
`else
  localparam logic [7:0] IDLE_B = 8'hBC;
`endif

  typedef struct {
    logic dout;
    logic act;
    logic ld;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  v;
  } frm_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid0, valid1, valid2, valid3;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       data_out, load, active;

  exp_t exp_q[$];
  frm_t plan_q[$];
  logic bits_q[$];
  int   t;
  int   checks = 0;
  int   errors = 0;
  int   cyc_idx = 0;
  exp_t mon_e;

  phy_tx_serializer #(.SYNC_FRAMES(SF)) dut (
    .clk_32f        (clk),
    .default_values (rst),
    .valid0         (valid0),
    .valid1         (valid1),
    .valid2         (valid2),
    .valid3         (valid3),
    .data_in0       (data_in0),
    .data_in1       (data_in1),
    .data_in2       (data_in2),
    .data_in3       (data_in3),
    .data_out       (data_out),
    .load           (load),
    .active         (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
    checks++;
    if (act_v !== req_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_idx, act_v, req_v);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cyc_idx++;
      chk("data_out", {31'd0, data_out}, {31'd0, mon_e.dout});
      chk("active",   {31'd0, active},   {31'd0, mon_e.act});
      chk("load",     {31'd0, load},     {31'd0, mon_e.ld});
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) bits_q.push_back(b[k]);
  endtask

  // One clock: drive inputs before the edge and predict the outputs after it.
  task automatic cycle(input logic r);
    exp_t e;
    frm_t f;
    int   tn;
    bit   is_load;
    @(negedge clk);
    rst = r;
    tn = t + 1;
    is_load = !r && (tn >= SF * FB) && ((tn % FB) == 0);
    if (is_load) begin
      if (plan_q.size() > 0) begin
        f = plan_q.pop_front();
      end else begin
        f.d = $urandom;
        f.v = 4'($urandom_range(0, 15));
      end
    end else begin
      f.d = $urandom;
      f.v = 4'($urandom_range(0, 15));
    end
    {data_in0, data_in1, data_in2, data_in3} = f.d;
    {valid3, valid2, valid1, valid0} = f.v;
    if (r) begin
      e.dout = 1'b0;
      e.act  = 1'b0;
      e.ld   = 1'b0;
      t = 0;
      bits_q.delete();
      for (int k = 0; k < SF * 4; k++) push_byte(8'hBC);
    end else begin
      t = tn;
      e.dout = bits_q.pop_front();
      e.act  = (t >= SF * FB);
      e.ld   = ((t % FB) == FB - 1) && (t + 1 >= SF * FB);
      if (is_load) begin
        for (int l = 0; l < 4; l++) begin
          push_byte(f.v[l] ? f.d[31 - 8 * l -: 8] : IDLE_B);
        end
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {valid0, valid1, valid2, valid3} = 4'b0;
    {data_in0, data_in1, data_in2, data_in3} = 32'd0;
    t = 0;
    plan_q.push_back('{d: 32'hFFEEDDCC, v: 4'b1111});
    plan_q.push_back('{d: 32'hBBAA9988, v: 4'b1111});
    plan_q.push_back('{d: 32'h11223344, v: 4'b0101});
    plan_q.push_back('{d: 32'hBC7C00BC, v: 4'b1011});

    cycle(1'b1);
    cycle(1'b1);
    repeat (SF * FB + 8 * FB) cycle(1'b0);

    while ((t % FB) != 13) cycle(1'b0);
    cycle(1'b1);

    repeat (SF * FB + 3 * FB + 5) cycle(1'b0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
